// File: rtl/fp_mul_if.sv
// Operand/result handshake bundle for the pipelined floating-point multiplier.
// The master side stages operands and consumes results; the slave is the multiplier.
interface fp_mul_if #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] product;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, flags
  );
endinterface

// File: rtl/fp_multiplier_pipelined.sv
// Three-stage valid/ready floating-point multiplier: classify/exponent, significand
// product, normalise/round/pack. Subnormals flush to zero; flags = {inv, ovf, unf, inx}.
module fp_multiplier_pipelined #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic      clk,
  input  logic      rst_n,
  fp_mul_if.slave   bus
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int EW2 = EXP_W + 2;
  localparam int SW  = MAN_W + 1;
  localparam int PW  = 2 * SW;
  localparam logic signed [EW2-1:0] EXP_INF = EW2'(2**EXP_W - 1);

  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_e;

  logic adv1, adv2, adv3;

  logic             v1_q, v1_d;
  logic             sign1_q, sign1_d;
  logic [EW2-1:0]   exp1_q, exp1_d;
  special_e         spec1_q, spec1_d;
  logic [SW-1:0]    siga1_q, siga1_d, sigb1_q, sigb1_d;

  logic             v2_q, v2_d;
  logic             sign2_q, sign2_d;
  logic [EW2-1:0]   exp2_q, exp2_d;
  special_e         spec2_q, spec2_d;
  logic [PW-1:0]    prod2_q, prod2_d;

  logic             v3_q, v3_d;
  logic [W-1:0]     product_q, product_d;
  logic [3:0]       flags_q, flags_d;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  special_e         spec_in;

  logic [PW-2:0]    norm;
  logic [MAN_W-1:0] man;
  logic             guard, sticky, rnd_up;
  logic [MAN_W:0]   man_r;
  logic [EW2-1:0]   e_u;
  logic signed [EW2-1:0] e_s;
  logic [W-1:0]     res_w;
  logic [3:0]       res_f;

  // A stage moves when it is empty or its successor is moving.
  always_comb begin
    adv3 = !v3_q || bus.out_ready;
    adv2 = !v2_q || adv3;
    adv1 = !v1_q || adv2;
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v3_q;
  assign bus.product   = product_q;
  assign bus.flags     = flags_q;

  assign ea = bus.a[W-2:MAN_W];
  assign eb = bus.b[W-2:MAN_W];
  assign ma = bus.a[MAN_W-1:0];
  assign mb = bus.b[MAN_W-1:0];

  always_comb begin
    a_nan  = (&ea) && (|ma);
    b_nan  = (&eb) && (|mb);
    a_inf  = (&ea) && !(|ma);
    b_inf  = (&eb) && !(|mb);
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    spec_in = SP_NONE;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) spec_in = SP_NAN;
    else if (a_inf || b_inf)                                       spec_in = SP_INF;
    else if (a_zero || b_zero)                                     spec_in = SP_ZERO;
  end

  always_comb begin
    v1_d    = v1_q;
    sign1_d = sign1_q;
    exp1_d  = exp1_q;
    spec1_d = spec1_q;
    siga1_d = siga1_q;
    sigb1_d = sigb1_q;
    if (adv1) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        sign1_d = bus.a[W-1] ^ bus.b[W-1];
        exp1_d  = EW2'(ea) + EW2'(eb) - EW2'(BIAS);
        spec1_d = spec_in;
        siga1_d = {1'b1, ma};
        sigb1_d = {1'b1, mb};
      end
    end
  end

  always_comb begin
    v2_d    = v2_q;
    sign2_d = sign2_q;
    exp2_d  = exp2_q;
    spec2_d = spec2_q;
    prod2_d = prod2_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        sign2_d = sign1_q;
        exp2_d  = exp1_q;
        spec2_d = spec1_q;
        prod2_d = PW'(siga1_q) * PW'(sigb1_q);
      end
    end
  end

  // Product lies in [1,4); align so the hidden one is dropped and the rest is left-justified.
  always_comb begin
    norm   = prod2_q[PW-1] ? prod2_q[PW-2:0] : {prod2_q[PW-3:0], 1'b0};
    man    = norm[PW-2 -: MAN_W];
    guard  = norm[PW-2-MAN_W];
    sticky = |norm[PW-3-MAN_W:0];
    rnd_up = guard && (sticky || man[0]);
    man_r  = {1'b0, man} + (MAN_W+1)'(rnd_up);
    e_u    = exp2_q + EW2'(prod2_q[PW-1]) + EW2'(man_r[MAN_W]);
    e_s    = $signed(e_u);

    res_w = '0;
    res_f = 4'b0000;
    case (spec2_q)
      SP_NAN: begin
        res_w = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        res_f = 4'b1000;
      end
      SP_INF:  res_w = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      SP_ZERO: res_w = {sign2_q, {(W-1){1'b0}}};
      default: begin
        if (e_s >= EXP_INF) begin
          res_w = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          res_f = 4'b0101;
        end else if (e_s <= 0) begin
          res_w = {sign2_q, {(W-1){1'b0}}};
          res_f = 4'b0011;
        end else begin
          res_w = {sign2_q, e_u[EXP_W-1:0], man_r[MAN_W-1:0]};
          res_f = {3'b000, guard || sticky};
        end
      end
    endcase
  end

  always_comb begin
    v3_d      = v3_q;
    product_d = product_q;
    flags_d   = flags_q;
    if (adv3) begin
      v3_d = v2_q;
      if (v2_q) begin
        product_d = res_w;
        flags_d   = res_f;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      sign1_q   <= 1'b0;
      exp1_q    <= '0;
      spec1_q   <= SP_NONE;
      siga1_q   <= '0;
      sigb1_q   <= '0;
      v2_q      <= 1'b0;
      sign2_q   <= 1'b0;
      exp2_q    <= '0;
      spec2_q   <= SP_NONE;
      prod2_q   <= '0;
      v3_q      <= 1'b0;
      product_q <= '0;
      flags_q   <= '0;
    end else begin
      v1_q      <= v1_d;
      sign1_q   <= sign1_d;
      exp1_q    <= exp1_d;
      spec1_q   <= spec1_d;
      siga1_q   <= siga1_d;
      sigb1_q   <= sigb1_d;
      v2_q      <= v2_d;
      sign2_q   <= sign2_d;
      exp2_q    <= exp2_d;
      spec2_q   <= spec2_d;
      prod2_q   <= prod2_d;
      v3_q      <= v3_d;
      product_q <= product_d;
      flags_q   <= flags_d;
    end
  end
endmodule

// File: tb/tb_fp_multiplier_pipelined.sv
// Bench for the E4M3 multiplier: directed vector table, backpressure, mid-flight reset,
// and randomised operands with random out_ready against an iterative reference model.
module tb_fp_multiplier_pipelined;
  localparam int EXP_W = 4;
  localparam int MAN_W = 3;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BIAS  = 7;
  localparam int NV    = 17;
  localparam int NRAND = 10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_mul_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_multiplier_pipelined #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] prod;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs [NV];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: shift the exact significand product right one bit at a time, tracking guard/sticky.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b);
    int ea, eb, ma, mb, p, e, g, s, emax;
    logic sp;
    logic [7:0] r;
    emax = 2**EXP_W - 1;
    sp = a[W-1] ^ b[W-1];
    ea = int'(a[W-2:MAN_W]);
    eb = int'(b[W-2:MAN_W]);
    ma = int'(a[MAN_W-1:0]);
    mb = int'(b[MAN_W-1:0]);
    if ((ea == emax && ma != 0) || (eb == emax && mb != 0) ||
        (ea == emax && eb == 0) || (eb == emax && ea == 0))
      return {4'b1000, 8'h7C};
    if (ea == emax || eb == emax) return {4'b0000, sp, 7'h78};
    if (ea == 0 || eb == 0)       return {4'b0000, sp, 7'h00};
    p = (ma + 8) * (mb + 8);
    e = ea + eb - BIAS - MAN_W;
    g = 0;
    s = 0;
    while (p >= 16) begin
      s = s | g;
      g = p & 1;
      p = p >> 1;
      e++;
    end
    if (g != 0 && (s != 0 || (p & 1) != 0)) p++;
    if (p == 16) begin
      p = p >> 1;
      e++;
    end
    if (e >= emax) return {4'b0101, sp, 7'h78};
    if (e <= 0)    return {4'b0011, sp, 7'h00};
    r = {sp, 4'(e), 3'(p)};
    return {3'b000, logic'(g != 0 || s != 0), r};
  endfunction

  task automatic run_vec(input vec_t v, input string name);
    int cyc;
    @(posedge clk); #1;
    bus.a = v.a;
    bus.b = v.b;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({name, " in_ready"}, 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, cyc, 3);
    check({name, " product"}, 32'(bus.product), 32'(v.prod));
    check({name, " flags"}, 32'(bus.flags), 32'(v.flags));
    @(posedge clk); #1;
    check({name, " valid drop"}, 32'(bus.out_valid), 0);
  endtask

  initial begin
    vecs[0]  = '{8'h3C, 8'h3C, 8'h41, 4'b0000};
    vecs[1]  = '{8'h3C, 8'h3E, 8'h42, 4'b0001};
    vecs[2]  = '{8'h39, 8'h39, 8'h3A, 4'b0001};
    vecs[3]  = '{8'h77, 8'h40, 8'h78, 4'b0101};
    vecs[4]  = '{8'h08, 8'h88, 8'h80, 4'b0011};
    vecs[5]  = '{8'h78, 8'h00, 8'h7C, 4'b1000};
    vecs[6]  = '{8'hF8, 8'h40, 8'hF8, 4'b0000};
    vecs[7]  = '{8'h7F, 8'h38, 8'h7C, 4'b1000};
    vecs[8]  = '{8'h38, 8'h38, 8'h38, 4'b0000};
    vecs[9]  = '{8'hB8, 8'h3C, 8'hBC, 4'b0000};
    vecs[10] = '{8'h00, 8'hC0, 8'h80, 4'b0000};
    vecs[11] = '{8'hF8, 8'hF8, 8'h78, 4'b0000};
    vecs[12] = '{8'h40, 8'h7A, 8'h7C, 4'b1000};
    vecs[13] = '{8'h38, 8'h08, 8'h08, 4'b0000};
    vecs[14] = '{8'h77, 8'h38, 8'h77, 4'b0000};
    vecs[15] = '{8'h40, 8'h70, 8'h78, 4'b0101};
    vecs[16] = '{8'h08, 8'h30, 8'h00, 4'b0011};

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;

    #1;
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset product", 32'(bus.product), 0);
    check("reset flags", 32'(bus.flags), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post reset in_ready", 32'(bus.in_ready), 1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    begin : backpressure
      int sent, rcv, cyc;
      logic [7:0] held_p;
      sent = 0;
      rcv = 0;
      cyc = 0;
      held_p = '0;
      bus.out_ready = 1'b0;
      while ((sent < 6 || rcv < 6) && cyc < 60) begin
        @(posedge clk); #1;
        bus.in_valid = (sent < 6);
        if (sent < 6) begin
          bus.a = vecs[sent].a;
          bus.b = vecs[sent].b;
        end
        bus.out_ready = (cyc >= 10);
        @(negedge clk);
        if (cyc == 5) held_p = bus.product;
        if (cyc == 9) begin
          check("bp accepts", sent, 3);
          check("bp in_ready", 32'(bus.in_ready), 0);
          check("bp out_valid", 32'(bus.out_valid), 1);
          check("bp hold", 32'(bus.product), 32'(held_p));
          check("bp head", 32'(bus.product), 32'(vecs[0].prod));
        end
        if (bus.in_valid && bus.in_ready) sent++;
        if (bus.out_valid && bus.out_ready) begin
          check($sformatf("bp product%0d", rcv), 32'(bus.product), 32'(vecs[rcv].prod));
          check($sformatf("bp flags%0d", rcv), 32'(bus.flags), 32'(vecs[rcv].flags));
          rcv++;
        end
        cyc++;
      end
      check("bp received", rcv, 6);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("bp no extra", 32'(bus.out_valid), 0);
    end

    begin : mid_reset
      int spurious;
      spurious = 0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.a = vecs[8+i].a;
        bus.b = vecs[8+i].b;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("inflight out_valid", 32'(bus.out_valid), 1);
      check("inflight product", 32'(bus.product), 32'(vecs[8].prod));
      rst_n = 1'b0;
      #1;
      check("mid reset out_valid", 32'(bus.out_valid), 0);
      check("mid reset product", 32'(bus.product), 0);
      check("mid reset flags", 32'(bus.flags), 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (bus.out_valid) spurious++;
      end
      check("mid reset spurious", spurious, 0);
      run_vec(vecs[1], "after reset");
    end

    begin : random_run
      logic [11:0] expq [$];
      logic [11:0] exp_r;
      logic [7:0]  held_p;
      logic [3:0]  held_f;
      logic        held, newop;
      int acc, cyc;
      acc = 0;
      cyc = 0;
      held = 1'b0;
      held_p = '0;
      held_f = '0;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      while ((acc < NRAND || expq.size() > 0) && cyc < 60000) begin
        @(negedge clk);
        if (held) begin
          check("rand hold valid", 32'(bus.out_valid), 1);
          check("rand hold product", 32'(bus.product), 32'(held_p));
          check("rand hold flags", 32'(bus.flags), 32'(held_f));
        end
        held = bus.out_valid && !bus.out_ready;
        held_p = bus.product;
        held_f = bus.flags;
        if (bus.out_valid && bus.out_ready) begin
          if (expq.size() == 0) begin
            check("rand spurious output", 1, 0);
          end else begin
            exp_r = expq.pop_front();
            check("rand product", 32'(bus.product), 32'(exp_r[7:0]));
            check("rand flags", 32'(bus.flags), 32'(exp_r[11:8]));
          end
        end
        newop = bus.in_valid && bus.in_ready;
        if (newop) begin
          expq.push_back(model(bus.a, bus.b));
          acc++;
        end
        @(posedge clk); #1;
        cyc++;
        if (newop || !bus.in_valid) begin
          bus.in_valid = (acc < NRAND) && ($urandom_range(0, 3) != 0);
          bus.a = 8'($urandom);
          bus.b = 8'($urandom);
        end
        bus.out_ready = ($urandom_range(0, 2) != 0);
      end
      check("rand accepted", acc, NRAND);
      check("rand drained", expq.size(), 0);
      bus.in_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_multiplier_pipelined.md
Name: fp_multiplier_pipelined

Overview:
- Parametrised, pipelined successor to the team's combinational FP8 multiplier.
- Multiplies two sign/exponent/mantissa floating-point operands of configurable format.
- Has a 3-stage valid/ready pipeline, round-to-nearest-even, exponent overflow/underflow handling, canonical NaN output and exception flags.
- Sits between operand staging and the MAC accumulator.

Parameters:
- EXP_W, 4, exponent field width (>=3)
- MAN_W, 3, stored mantissa field width (>=2); word width W = 1+EXP_W+MAN_W
- BIAS, 2**(EXP_W-1)-1, exponent bias

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  pipeline can accept an operand pair
- a  in  W  operand A {sign, exp, man}
- b  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- product  out  W  result
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with product

Behaviour:
- Encoding:
  - exp all-ones, man==0: infinity. exp all-ones, man!=0: NaN.
  - exp==0: zero; subnormals are treated as zero on input and are never produced.
- Pipeline, one register per stage, each with its own valid bit:
  - S1: classify operands; sign_p = sa^sb; signed exponent sum ea+eb-BIAS at width EXP_W+2; latch special-case code.
  - S2: unsigned (MAN_W+1)x(MAN_W+1) product of the significands with hidden 1.
  - S3: normalise (if MSB set, shift right 1 and add 1 to exponent); RNE round using guard bit and sticky OR; if rounding carries out the mantissa, exponent +1; range check; pack.
- Latency: 3 cycles from accept (in_valid&&in_ready) to out_valid when out_ready stays high. Throughput 1 per cycle.
- Handshake:
  - Stage k advances when its register is empty or stage k+1 advances. S3 advances when !out_valid || out_ready.
  - in_ready = S1 empty || S1 advances. It is combinational from out_ready; there is no combinational path from in_valid.
  - product/flags are held stable while out_valid && !out_ready.
  - No loss or reorder. At most 3 results are buffered under full stall.
- Special cases, highest priority first:
  - Any NaN input, or inf x zero: product = {0, all-ones, 1, zeros} (canonical quiet NaN, 0x7C for E4M3); invalid=1.
  - inf x finite-nonzero or inf x inf: {sign_p, all-ones, 0}; no flags.
  - zero x finite: {sign_p, 0, 0}; no flags.
- Finite range, e = final exponent after normalise and round:
  - e >= 2**EXP_W-1: infinity with sign_p; overflow=1 and inexact=1.
  - e <= 0: signed zero; underflow=1 and inexact=1.
  - otherwise: normal result; inexact=1 iff any discarded bit was nonzero.
- Reset (async assert, sync-release by the top level):
  - All stage valids clear, so out_valid=0.
  - product=0 and flags=0.
  - in_ready=1 from the first cycle after deassert.
  - In-flight operations are discarded and no stale result appears after reset.
- Simultaneous accept and S3 drain with a full pipeline: legal, every stage shifts, and the count of held items is unchanged.

Test Plan (E4M3 default):
- a=0x3C (1.5), b=0x3C, out_ready=1 -> product 0x41 (2.25), flags 0000, out_valid exactly 3 cycles after accept.
- a=0x3C (1.5), b=0x3E (1.75) -> exact 2.625 is a tie; RNE gives 0x42 (2.5), inexact=1. Also a=0x39, b=0x39 (1.125^2) -> 0x3A, inexact=1.
- Range limits:
  - a=0x77 (240), b=0x40 (2.0) -> 0x78 (+inf), flags 0101.
  - a=0x08, b=0x88 -> 0x80 (-0), flags 0011.
- Specials:
  - a=0x78, b=0x00 -> 0x7C, flags 1000.
  - a=0xF8, b=0x40 -> 0xF8, flags 0000.
  - a=0x7F (NaN), b=0x38 -> 0x7C, invalid=1.
- Backpressure: stream 6 back-to-back pairs with out_ready=0 -> in_ready drops after 3 accepts and product holds steady. Then release out_ready -> all 6 results emerge in order, none lost or duplicated. Random out_ready toggling is checked against a reference model over 10k random operands.
- Reset mid-operation: assert rst_n=0 with 3 items in flight -> out_valid=0 immediately and product=0. After release there are no spurious outputs, and a new pair returns the correct result in 3 cycles.
